seg7_dynamic_scanner: RTL and testbench
=======================================

// Module: seg7_dynamic_scanner
//
// PURPOSE
// - Drives a multiplexed 7-segment display from per-digit static segment registers.
// - Scans the digits in time and produces a segment bus hgfedcba plus a one-hot digit-select bus.
// - Inserts a blanking gap between digits to suppress ghosting.
// - Latches all digit values once per frame into a shadow buffer, so a frame never mixes old and new data.
// - Sits between lab logic holding hex[] values and the board's dynamic display pins.
//   It is the transmit-side counterpart of the capture block that rebuilds hex[] from hgfedcba/digit.
//
// PARAMETERS
// - w_digit       8     number of digits scanned; digit 0 is scanned first.
// - w_seg         8     segment bits per digit (hgfedcba, h = decimal point).
// - digit_period  4096  clock cycles per digit slot; must be >= 2.
// - blank_cycles  16    blanked cycles at the start of each slot; must be < digit_period.
//
// PORTS
// - clk          in   1              system clock
// - rst          in   1              synchronous reset, active-high
// - en           in   1              scan enable; low = display dark, scanner parked
// - hex          in   w_seg x w_digit  static segment pattern per digit (unpacked array hex[w_digit])
// - hgfedcba     out  w_seg          segment bus for the currently driven digit, active-high
// - digit        out  w_digit        one-hot digit select, active-high; all-zero while blanking
// - frame_start  out  1              one-cycle pulse on the first cycle of slot 0 of each frame
//
// BEHAVIOUR
// - State is slot index idx (0..w_digit-1) and slot counter cnt (0..digit_period-1), width $clog2(digit_period).
// - Reset (rst=1 at posedge):
//   - idx=0, cnt=0, shadow=0.
//   - Outputs hgfedcba=0, digit=0, frame_start=0.
//   - rst has priority over en.
// - Parked (en=0): idx=0, cnt=0, outputs 0, shadow held.
// - Running (en=1): cnt increments every cycle.
//   - At cnt==digit_period-1, cnt wraps to 0 and idx advances.
//   - idx wraps from w_digit-1 to 0.
// - Outputs are registered and aligned to the state of the same cycle:
//   - BLANK (cnt < blank_cycles): digit=0, hgfedcba=0.
//   - DRIVE (cnt >= blank_cycles): digit = 1<<idx, hgfedcba = shadow[idx].
// - frame_start=1 exactly in cycles with en=1, idx==0, cnt==0.
// - Shadow load: shadow <= hex on the cycle that begins a frame.
//   - That is the first en=1 cycle after reset or parking, and each idx/cnt wrap into slot 0.
//   - The load is visible to slot 0's DRIVE phase of the same frame.
//   - hex changes mid-frame take effect only at the next frame.
// - Frame length = w_digit*digit_period cycles. Each digit is lit for digit_period-blank_cycles cycles per frame.
// - At most one digit bit is high in any cycle. digit and hgfedcba change only on slot/phase edges.
// - en falling mid-slot: the next cycle is parked, with outputs 0.
//   - A later en rise restarts at slot 0 with a fresh snapshot and a frame_start pulse.
// - rst asserted mid-frame: identical to power-on reset on the next cycle.
// - blank_cycles=0: no blank phase; adjacent digits switch with zero gap.
//
// TESTING
// All tests use w_digit=4, w_seg=8, digit_period=8, blank_cycles=2 unless noted.
// - Reset/park: rst=1, hex={8'h3F,8'h06,8'h5B,8'h4F}, en=0 -> digit=0, hgfedcba=0, frame_start=0 for 50 cycles.
// - Basic scan: en=1 after reset.
//   - frame_start pulses every 32 cycles.
//   - Cycles 0-1 of the frame: digit=0. Cycles 2-7: digit=4'b0001, seg=8'h3F.
//   - Cycles 10-15: digit=4'b0010, seg=8'h06; then 4'b0100/8'h5B and 4'b1000/8'h4F.
// - Tear-free update: change hex[0] to 8'h77 during slot 2 -> remainder of frame unchanged.
//   - The next frame's slot 0 shows 8'h77.
// - en drop: en=0 at cycle 13 of a frame -> outputs 0 from the next cycle.
//   - en=1 later -> frame_start that cycle, slot 0 restarts with the current hex.
// - Mid-frame reset: rst=1 in slot 3 DRIVE -> outputs 0 next cycle.
//   - After release, scan resumes at slot 0 with frame_start.
// - Edge params: digit_period=2, blank_cycles=0 -> digit bit i high continuously for 2 cycles each, no gaps.
//   - A one-hot check holds in every cycle of all tests.

Source files
------------

// File: rtl/seg7_dynamic_scanner.sv
// Time-multiplexed 7-segment driver: scans w_digit slots with a leading blank gap per slot,
// snapshotting hex[] into a shadow buffer at every frame start so a frame never mixes data.
module seg7_dynamic_scanner #(
  parameter int w_digit      = 8,
  parameter int w_seg        = 8,
  parameter int digit_period = 4096,
  parameter int blank_cycles = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic [w_seg-1:0]   i_hex [w_digit],
  output logic [w_seg-1:0]   o_hgfedcba,
  output logic [w_digit-1:0] o_digit,
  output logic               o_frame_start
);

  localparam int CW = (digit_period > 1) ? $clog2(digit_period) : 1;
  localparam int IW = (w_digit > 1) ? $clog2(w_digit) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(digit_period - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(w_digit - 1);

  typedef enum logic {PARK, RUN} state_t;

  state_t             r_state, w_state_nx;
  logic [CW-1:0]      r_cnt, w_cnt_nx;
  logic [IW-1:0]      r_idx, w_idx_nx;
  logic [w_seg-1:0]   r_shadow [w_digit];
  logic               w_load;
  logic [w_seg-1:0]   w_seg_nx;
  logic [w_digit-1:0] w_digit_nx;
  logic               w_fs_nx;

  // r_idx/r_cnt name the slot position whose outputs are currently on the pins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= PARK;
      r_cnt         <= '0;
      r_idx         <= '0;
      o_hgfedcba    <= '0;
      o_digit       <= '0;
      o_frame_start <= 1'b0;
      for (int i = 0; i < w_digit; i++) r_shadow[i] <= '0;
    end else begin
      r_state       <= w_state_nx;
      r_cnt         <= w_cnt_nx;
      r_idx         <= w_idx_nx;
      o_hgfedcba    <= w_seg_nx;
      o_digit       <= w_digit_nx;
      o_frame_start <= w_fs_nx;
      if (w_load) r_shadow <= i_hex;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_idx_nx   = r_idx;
    if (!i_en) begin
      w_state_nx = PARK;
      w_cnt_nx   = '0;
      w_idx_nx   = '0;
    end else if (r_state == PARK) begin
      w_state_nx = RUN;
      w_cnt_nx   = '0;
      w_idx_nx   = '0;
    end else begin
      w_state_nx = RUN;
      if (r_cnt == LAST_CNT) begin
        w_cnt_nx = '0;
        w_idx_nx = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
      end else begin
        w_cnt_nx = r_cnt + 1'b1;
      end
    end
  end

  assign w_load = i_en && (w_cnt_nx == '0) && (w_idx_nx == '0);

  // Snapshot bypass keeps slot 0 correct when there is no blank phase to hide the load.
  always_comb begin
    w_seg_nx   = '0;
    w_digit_nx = '0;
    w_fs_nx    = 1'b0;
    if (w_state_nx == RUN) begin
      w_fs_nx = w_load;
      if (int'(w_cnt_nx) >= blank_cycles) begin
        w_digit_nx = w_digit'(1) << w_idx_nx;
        w_seg_nx   = w_load ? i_hex[w_idx_nx] : r_shadow[w_idx_nx];
      end
    end
  end

endmodule

// File: tb/tb_seg7_dynamic_scanner.sv
// Bench for seg7_dynamic_scanner: two instances (8/2 and 2/0 period/blank) checked every
// cycle against a frame-position reference model under directed and random stimulus.
module tb_seg7_dynamic_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] hex [4];

  logic [7:0] seg_a, seg_b;
  logic [3:0] dig_a, dig_b;
  logic       fs_a, fs_b;

  int checks = 0;
  int errors = 0;

  // Reference model state, per instance (0: period 8 blank 2, 1: period 2 blank 0)
  bit         run_m  [2];
  int         pos_m  [2];
  logic [7:0] snap_m [2][4];
  logic [7:0] exp_seg [2];
  logic [3:0] exp_dig [2];
  logic       exp_fs  [2];

  always #5 clk = ~clk;

  seg7_dynamic_scanner #(.w_digit(4), .w_seg(8), .digit_period(8), .blank_cycles(2)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_hex(hex),
    .o_hgfedcba(seg_a), .o_digit(dig_a), .o_frame_start(fs_a)
  );

  seg7_dynamic_scanner #(.w_digit(4), .w_seg(8), .digit_period(2), .blank_cycles(0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_hex(hex),
    .o_hgfedcba(seg_b), .o_digit(dig_b), .o_frame_start(fs_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame position arithmetic: slot = pos / period, offset in slot = pos % period.
  task automatic model_tick();
    int p, b, frame, slot;
    for (int k = 0; k < 2; k++) begin
      p = (k == 0) ? 8 : 2;
      b = (k == 0) ? 2 : 0;
      frame = 4 * p;
      exp_seg[k] = '0;
      exp_dig[k] = '0;
      exp_fs[k]  = 1'b0;
      if (rst) begin
        run_m[k] = 1'b0;
        pos_m[k] = 0;
        for (int j = 0; j < 4; j++) snap_m[k][j] = '0;
      end else if (!en) begin
        run_m[k] = 1'b0;
        pos_m[k] = 0;
      end else begin
        pos_m[k] = run_m[k] ? (pos_m[k] + 1) % frame : 0;
        run_m[k] = 1'b1;
        if (pos_m[k] == 0)
          for (int j = 0; j < 4; j++) snap_m[k][j] = hex[j];
        exp_fs[k] = (pos_m[k] == 0);
        slot = pos_m[k] / p;
        if ((pos_m[k] % p) >= b) begin
          exp_dig[k] = 4'b0001 << slot;
          exp_seg[k] = snap_m[k][slot];
        end
      end
    end
  endtask

  task automatic step();
    model_tick();
    @(posedge clk);
    #1;
    chk("a_seg",    32'(seg_a), 32'(exp_seg[0]));
    chk("a_digit",  32'(dig_a), 32'(exp_dig[0]));
    chk("a_fstart", 32'(fs_a),  32'(exp_fs[0]));
    chk("a_onehot", 32'($countones(dig_a) <= 1), 32'd1);
    chk("b_seg",    32'(seg_b), 32'(exp_seg[1]));
    chk("b_digit",  32'(dig_b), 32'(exp_dig[1]));
    chk("b_fstart", 32'(fs_b),  32'(exp_fs[1]));
    chk("b_onehot", 32'($countones(dig_b) <= 1), 32'd1);
  endtask

  // Advance instance A until its last shown frame position equals target (bounded).
  task automatic advance_to(input int target);
    for (int i = 0; i < 100 && !(run_m[0] && pos_m[0] == target); i++) step();
    if (!(run_m[0] && pos_m[0] == target)) begin
      checks++;
      errors++;
      $error("FAIL advance_to position=%0d expected=%0d", pos_m[0], target);
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    hex[0] = 8'h3F; hex[1] = 8'h06; hex[2] = 8'h5B; hex[3] = 8'h4F;
    for (int k = 0; k < 2; k++) begin
      run_m[k] = 1'b0;
      pos_m[k] = 0;
      for (int j = 0; j < 4; j++) snap_m[k][j] = '0;
    end

    // Reset and park
    for (int i = 0; i < 50; i++) step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // Basic scan, two full frames
    en = 1'b1;
    for (int i = 0; i < 64; i++) step();

    // Tear-free update during slot 2
    advance_to(17);
    hex[0] = 8'h77;
    for (int i = 0; i < 48; i++) step();

    // en drop so that frame cycle 13 is parked, then restart
    advance_to(12);
    en = 1'b0;
    for (int i = 0; i < 5; i++) step();
    hex[1] = 8'h6D;
    en = 1'b1;
    for (int i = 0; i < 40; i++) step();

    // Reset during slot 3 drive phase
    advance_to(27);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) step();

    // Random hex updates, enable toggles and occasional resets
    for (int i = 0; i < 600; i++) begin
      for (int j = 0; j < 4; j++)
        if ($urandom_range(19, 0) == 0) hex[j] = 8'($urandom);
      if ($urandom_range(49, 0) == 0) en = ~en;
      rst = ($urandom_range(199, 0) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
